cdc_fifo_drain_arbiter: RTL

- Sits in the 50 MHz control domain (dst_clk) on the read side of up to NUM_SRC async_fifo instances, e.g. result FIFOs from the 200 MHz datapath.
- Pops the FIFOs round-robin with a bounded burst per source.
- Merges the popped words into one valid/ready stream, each word tagged with its source index.
- Hides the FIFOs' 1-cycle registered read latency, sustaining 1 word/cycle with no drops under backpressure.

---
 rtl/cdc_arb_pkg.sv | 20 ++
 rtl/cdc_fifo_drain_arbiter_out_buf.sv | 54 +++++
 rtl/cdc_fifo_drain_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/cdc_arb_pkg.sv
// Shared constants and types for the FIFO drain arbiter: output buffer depth,
// source-index width helper and the drain-buffer entry layout.
package cdc_arb_pkg;

    localparam int OUT_BUF_DEPTH  = 2;
    localparam int OCC_W          = $clog2(OUT_BUF_DEPTH + 1);
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_NUM_SRC    = 4;

    function automatic int src_id_width(input int num_src);
        return (num_src > 1) ? $clog2(num_src) : 1;
    endfunction

    // Layout for the default configuration; the top passes its own sized variant.
    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0]    data;
        logic [$clog2(DEF_NUM_SRC)-1:0] src_id;
    } drain_entry_t;

endpackage

// File: rtl/cdc_fifo_drain_arbiter_out_buf.sv
// Two-entry valid/ready skid buffer; its occupancy feeds the arbiter's credit check.
module drain_out_buf
    import cdc_arb_pkg::*;
#(
    parameter type entry_t = drain_entry_t
) (
    input  logic             dst_clk,
    input  logic             dst_rst_n,
    input  logic             push,
    input  entry_t           push_entry,
    output logic             out_valid,
    input  logic             out_ready,
    output entry_t           out_entry,
    output logic [OCC_W-1:0] count
);

    localparam int PTR_W = $clog2(OUT_BUF_DEPTH);

    entry_t           mem_reg [OUT_BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [OCC_W-1:0] count_reg;
    logic             pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUT_BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign out_valid = (count_reg != '0);
    assign pop       = out_valid & out_ready;
    assign out_entry = mem_reg[rd_ptr_reg];
    assign count     = count_reg;

    always_ff @(posedge dst_clk or negedge dst_rst_n) begin
        if (!dst_rst_n) begin
            for (int i = 0; i < OUT_BUF_DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                mem_reg[wr_ptr_reg] <= push_entry;
                wr_ptr_reg          <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            count_reg <= count_reg + OCC_W'(push) - OCC_W'(pop);
        end
    end

endmodule

// File: rtl/cdc_fifo_drain_arbiter.sv
// Round-robin drain of several async FIFO read ports into one tagged valid/ready
// stream, with bounded bursts and credit-based hiding of the FIFO read latency.
module cdc_fifo_drain_arbiter
    import cdc_arb_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                               dst_clk,
    input  logic                               dst_rst_n,
    input  logic                               enable,
    input  logic [NUM_SRC-1:0]                 fifo_empty,
    output logic [NUM_SRC-1:0]                 fifo_rd_en,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]      fifo_rd_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [DATA_WIDTH-1:0]              out_data,
    output logic [src_id_width(NUM_SRC)-1:0]   out_src_id,
    output logic                               idle
);

    localparam int SRC_W   = src_id_width(NUM_SRC);
    localparam int BURST_W = $clog2(MAX_BURST + 1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [SRC_W-1:0]      src_id;
    } entry_t;

    logic [DATA_WIDTH-1:0] rd_word [NUM_SRC];
    logic [SRC_W-1:0]      rr_ptr_reg;
    logic [SRC_W-1:0]      cur_reg;
    logic [BURST_W-1:0]    burst_cnt_reg;
    logic                  inflight_reg;
    logic [SRC_W-1:0]      inflight_src_reg;

    logic [OCC_W-1:0]      occ;
    logic                  buf_valid;
    entry_t                buf_entry;
    entry_t                push_entry;
    logic                  hs;
    logic [OCC_W:0]        committed;
    logic                  credit_ok;
    logic                  keep;
    logic                  found;
    logic [SRC_W-1:0]      winner;
    logic                  pop_en;
    logic [SRC_W-1:0]      pop_src;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign rd_word[gi]    = fifo_rd_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign fifo_rd_en[gi] = pop_en && (pop_src == SRC_W'(gi));
        end
    endgenerate

    // Slots already spoken for once this cycle's output handshake retires a word.
    assign hs        = buf_valid & out_ready;
    assign committed = {1'b0, occ} + {{OCC_W{1'b0}}, inflight_reg} - {{OCC_W{1'b0}}, hs};
    assign credit_ok = committed < (OCC_W + 1)'(OUT_BUF_DEPTH);

    assign keep = (burst_cnt_reg != '0) && !fifo_empty[cur_reg]
                  && (burst_cnt_reg < BURST_W'(MAX_BURST));

    // Descending scan so the candidate closest to rr_ptr is the last to win.
    always_comb begin
        winner = rr_ptr_reg;
        found  = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (!fifo_empty[(int'(rr_ptr_reg) + i) % NUM_SRC]) begin
                winner = SRC_W'((int'(rr_ptr_reg) + i) % NUM_SRC);
                found  = 1'b1;
            end
        end
    end

    assign pop_en  = dst_rst_n && enable && credit_ok && (keep || found);
    assign pop_src = keep ? cur_reg : winner;

    always_ff @(posedge dst_clk or negedge dst_rst_n) begin
        if (!dst_rst_n) begin
            rr_ptr_reg       <= '0;
            cur_reg          <= '0;
            burst_cnt_reg    <= '0;
            inflight_reg     <= 1'b0;
            inflight_src_reg <= '0;
        end else begin
            inflight_reg     <= pop_en;
            inflight_src_reg <= pop_src;
            if (pop_en) begin
                if (keep) begin
                    burst_cnt_reg <= burst_cnt_reg + 1'b1;
                end else begin
                    cur_reg       <= winner;
                    burst_cnt_reg <= BURST_W'(1);
                    rr_ptr_reg    <= (winner == SRC_W'(NUM_SRC - 1)) ? '0 : winner + 1'b1;
                end
            end else if (!enable || !keep) begin
                burst_cnt_reg <= '0;
            end
        end
    end

    assign push_entry.data   = rd_word[inflight_src_reg];
    assign push_entry.src_id = inflight_src_reg;

    drain_out_buf #(
        .entry_t (entry_t)
    ) u_out_buf (
        .dst_clk    (dst_clk),
        .dst_rst_n  (dst_rst_n),
        .push       (inflight_reg),
        .push_entry (push_entry),
        .out_valid  (buf_valid),
        .out_ready  (out_ready),
        .out_entry  (buf_entry),
        .count      (occ)
    );

    assign out_valid  = buf_valid;
    assign out_data   = buf_entry.data;
    assign out_src_id = buf_entry.src_id;
    assign idle       = !inflight_reg && (occ == '0);

endmodule
